// File: rtl/msg_pipe_reg.sv
// Pipeline register for the packed per-instruction message bus between stages.
// Adds stall hold, flush-to-bubble, Tnew countdown, first-exception ExcCode injection, stall counter.
module msg_pipe_reg #(
  parameter int MSG_W    = 192,
  parameter int TNEW_LSB = 0,
  parameter int TNEW_W   = 4,
  parameter int EXC_LSB  = 12,
  parameter int EXC_W    = 5,
  parameter int BD_BIT   = 17,
  parameter int PC_LSB   = 32,
  parameter int DEC_TNEW = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MSG_W-1:0] msg_in,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             req,
  input  logic             exc_valid,
  input  logic [EXC_W-1:0] exc_code,
  output logic [MSG_W-1:0] msg_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PC_W = 32;

  function automatic bit in_rng(input int lsb, input int w);
    return (lsb >= 0) && (w > 0) && (lsb + w <= MSG_W);
  endfunction

  function automatic bit ovl(input int a, input int aw, input int b, input int bw);
    return (a < b + bw) && (b < a + aw);
  endfunction

  localparam bit FIELDS_IN  = in_rng(TNEW_LSB, TNEW_W) && in_rng(EXC_LSB, EXC_W) &&
                              in_rng(PC_LSB, PC_W) && in_rng(BD_BIT, 1);
  localparam bit FIELDS_SEP = !ovl(TNEW_LSB, TNEW_W, EXC_LSB, EXC_W) &&
                              !ovl(TNEW_LSB, TNEW_W, PC_LSB, PC_W) &&
                              !ovl(EXC_LSB, EXC_W, PC_LSB, PC_W) &&
                              !ovl(BD_BIT, 1, TNEW_LSB, TNEW_W) &&
                              !ovl(BD_BIT, 1, EXC_LSB, EXC_W) &&
                              !ovl(BD_BIT, 1, PC_LSB, PC_W);
  localparam bit PARAMS_OK  = FIELDS_IN && FIELDS_SEP &&
                              (DEC_TNEW == 0 || DEC_TNEW == 1) && (CNT_W >= 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("msg_pipe_reg: illegal field map or parameter set");
    end
  endgenerate

  logic [MSG_W-1:0]  r_msg;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic [TNEW_W-1:0] w_tnew_in;
  logic [EXC_W-1:0]  w_exc_in;
  logic [MSG_W-1:0]  w_load;
  logic [MSG_W-1:0]  w_bubble;

  // Field edits apply only to real instructions; bubbles pass verbatim.
  always_comb begin
    w_tnew_in = msg_in[TNEW_LSB +: TNEW_W];
    w_exc_in  = msg_in[EXC_LSB +: EXC_W];
    w_load    = msg_in;
    if (valid_in) begin
      if (DEC_TNEW == 1 && w_tnew_in != '0)
        w_load[TNEW_LSB +: TNEW_W] = w_tnew_in - TNEW_W'(1);
      if (exc_valid && w_exc_in == '0)
        w_load[EXC_LSB +: EXC_W] = exc_code;
    end
  end

  // Bubble keeps PC and BD so an interrupt taken on it still reports the right EPC.
  always_comb begin
    w_bubble                  = '0;
    w_bubble[PC_LSB +: PC_W]  = msg_in[PC_LSB +: PC_W];
    w_bubble[BD_BIT]          = msg_in[BD_BIT];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_msg   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (req) begin
      r_msg   <= '0;
      r_valid <= 1'b0;
    end else if (stall) begin
      if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (flush) begin
      r_msg   <= w_bubble;
      r_valid <= 1'b0;
    end else begin
      r_msg   <= w_load;
      r_valid <= valid_in;
    end
  end

  assign msg_out   = r_msg;
  assign valid_out = r_valid;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_msg_pipe_reg.sv
// Self-checking bench for msg_pipe_reg: directed scenarios plus randomized run against a field-level reference model.
module tb_msg_pipe_reg;
  localparam int MW = 192;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] msg_in;
  logic          valid_in, stall, flush, req, exc_valid;
  logic [4:0]    exc_code;

  logic [MW-1:0] msg_d, msg_s2, msg_s3, msg_nd, msg_c2;
  logic          vld_d, vld_s2, vld_s3, vld_nd, vld_c2;
  logic [15:0]   cnt_d, cnt_s2, cnt_s3, cnt_nd;
  logic [1:0]    cnt_c2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [MW-1:0] e_msg, e_nd_msg;
  logic          e_vld;
  int            e_cnt, e_c2;

  always #5 clk = ~clk;

  msg_pipe_reg u_dut (.clk(clk), .reset(reset), .msg_in(msg_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .req(req), .exc_valid(exc_valid), .exc_code(exc_code),
    .msg_out(msg_d), .valid_out(vld_d), .stall_cnt(cnt_d));

  msg_pipe_reg u_s2 (.clk(clk), .reset(reset), .msg_in(msg_d), .valid_in(vld_d),
    .stall(1'b0), .flush(1'b0), .req(1'b0), .exc_valid(1'b0), .exc_code(5'd0),
    .msg_out(msg_s2), .valid_out(vld_s2), .stall_cnt(cnt_s2));

  msg_pipe_reg u_s3 (.clk(clk), .reset(reset), .msg_in(msg_s2), .valid_in(vld_s2),
    .stall(1'b0), .flush(1'b0), .req(1'b0), .exc_valid(1'b0), .exc_code(5'd0),
    .msg_out(msg_s3), .valid_out(vld_s3), .stall_cnt(cnt_s3));

  msg_pipe_reg #(.DEC_TNEW(0)) u_nd (.clk(clk), .reset(reset), .msg_in(msg_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .req(req), .exc_valid(exc_valid), .exc_code(exc_code),
    .msg_out(msg_nd), .valid_out(vld_nd), .stall_cnt(cnt_nd));

  msg_pipe_reg #(.CNT_W(2)) u_c2 (.clk(clk), .reset(reset), .msg_in(msg_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .req(req), .exc_valid(exc_valid), .exc_code(exc_code),
    .msg_out(msg_c2), .valid_out(vld_c2), .stall_cnt(cnt_c2));

  function automatic logic [MW-1:0] rnd_msg();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Loaded value: Tnew counts down toward 0 (never below), ExcCode filled only if empty.
  function automatic logic [MW-1:0] ref_load(input logic [MW-1:0] m, input logic v,
                                             input logic ev, input logic [4:0] ec, input bit dec);
    logic [MW-1:0] r;
    int t;
    r = m;
    if (v) begin
      t = int'(m[3:0]);
      if (dec && t > 0) r[3:0] = 4'(t - 1);
      if (ev && m[16:12] == 5'd0) r[16:12] = ec;
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] ref_bubble(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    r = '0;
    r[63:32] = m[63:32];
    r[17]    = m[17];
    return r;
  endfunction

  // Advance the reference model by one edge from the current inputs, then clock the DUTs.
  task automatic step();
    logic [MW-1:0] n_msg, n_nd;
    logic n_vld;
    int n_cnt, n_c2;
    n_msg = e_msg; n_nd = e_nd_msg; n_vld = e_vld; n_cnt = e_cnt; n_c2 = e_c2;
    if (!reset) begin
      n_msg = '0; n_nd = '0; n_vld = 0; n_cnt = 0; n_c2 = 0;
    end else if (req) begin
      n_msg = '0; n_nd = '0; n_vld = 0;
    end else if (stall) begin
      n_cnt = (e_cnt + 1 > 65535) ? 65535 : e_cnt + 1;
      n_c2  = (e_c2 + 1 > 3) ? 3 : e_c2 + 1;
    end else if (flush) begin
      n_msg = ref_bubble(msg_in); n_nd = n_msg; n_vld = 0;
    end else begin
      n_msg = ref_load(msg_in, valid_in, exc_valid, exc_code, 1'b1);
      n_nd  = ref_load(msg_in, valid_in, exc_valid, exc_code, 1'b0);
      n_vld = valid_in;
    end
    @(posedge clk);
    #1;
    e_msg = n_msg; e_nd_msg = n_nd; e_vld = n_vld; e_cnt = n_cnt; e_c2 = n_c2;
  endtask

  task automatic idle_inputs();
    reset = 1; req = 0; stall = 0; flush = 0; exc_valid = 0; exc_code = '0;
    valid_in = 0; msg_in = '0;
  endtask

  task automatic test_reset();
    logic [MW-1:0] a5;
    for (int i = 0; i < 2; i++) begin
      reset = 0; msg_in = rnd_msg(); valid_in = 1'($urandom); stall = 1'($urandom);
      flush = 1'($urandom); req = 1'($urandom); exc_valid = 1'($urandom); exc_code = 5'($urandom);
      step();
    end
    n_tests++;
    if (msg_d !== '0 || vld_d !== 1'b0 || cnt_d !== 16'd0 || cnt_c2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: msg=%h vld=%b cnt=%0d cnt2=%0d want 0/0/0/0", msg_d, vld_d, cnt_d, cnt_c2);
    end
    idle_inputs();
    a5 = '0; a5[7:0] = 8'hA5;
    msg_in = a5; valid_in = 1;
    #2;
    n_tests++;
    if (msg_d !== '0) begin
      n_fail++;
      $display("FAIL no_comb_path: msg=%h want 0 before edge", msg_d);
    end
    step();
    a5[3:0] = 4'h4;
    n_tests++;
    if (msg_d !== a5 || vld_d !== 1'b1) begin
      n_fail++;
      $display("FAIL first_load: msg=%h vld=%b want %h/1", msg_d, vld_d, a5);
    end
  endtask

  task automatic test_tnew();
    logic [MW-1:0] m;
    idle_inputs();
    m = rnd_msg(); m[3:0] = 4'd2; m[16:12] = 5'd0;
    msg_in = m; valid_in = 1;
    step();
    n_tests++;
    if (msg_d[3:0] !== 4'd1 || msg_nd[3:0] !== 4'd2) begin
      n_fail++;
      $display("FAIL tnew_stage1: dec=%0d nodec=%0d want 1/2", msg_d[3:0], msg_nd[3:0]);
    end
    step();
    n_tests++;
    if (msg_s2[3:0] !== 4'd0 || vld_s2 !== 1'b1) begin
      n_fail++;
      $display("FAIL tnew_stage2: tnew=%0d vld=%b want 0/1", msg_s2[3:0], vld_s2);
    end
    step();
    n_tests++;
    if (msg_s3[3:0] !== 4'd0 || msg_s3[MW-1:4] !== m[MW-1:4]) begin
      n_fail++;
      $display("FAIL tnew_stage3_sat: tnew=%0d want 0 (rest intact)", msg_s3[3:0]);
    end
    m[3:0] = 4'd0; msg_in = m;
    step();
    n_tests++;
    if (msg_d[3:0] !== 4'd0) begin
      n_fail++;
      $display("FAIL tnew_zero: got %h want 0", msg_d[3:0]);
    end
    m[3:0] = 4'd3; msg_in = m;
    step();
    n_tests++;
    if (msg_nd !== m || msg_d[3:0] !== 4'd2) begin
      n_fail++;
      $display("FAIL tnew_nodec: nodec=%0d dec=%0d want 3/2", msg_nd[3:0], msg_d[3:0]);
    end
  endtask

  task automatic test_exc();
    logic [MW-1:0] m;
    idle_inputs();
    m = rnd_msg(); m[3:0] = 4'd0; m[16:12] = 5'd0;
    msg_in = m; valid_in = 1; exc_valid = 1; exc_code = 5'd4;
    step();
    n_tests++;
    if (msg_d[16:12] !== 5'd4 || msg_d[MW-1:17] !== m[MW-1:17] || msg_d[11:0] !== m[11:0]) begin
      n_fail++;
      $display("FAIL exc_inject: code=%0d want 4", msg_d[16:12]);
    end
    m[16:12] = 5'd10; msg_in = m;
    step();
    n_tests++;
    if (msg_d[16:12] !== 5'd10) begin
      n_fail++;
      $display("FAIL exc_first_wins: code=%0d want 10", msg_d[16:12]);
    end
    m[16:12] = 5'd0; m[3:0] = 4'd7; msg_in = m; valid_in = 0;
    step();
    n_tests++;
    if (msg_d !== m || vld_d !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_invalid_verbatim: msg=%h vld=%b want %h/0", msg_d, vld_d, m);
    end
  endtask

  task automatic test_flush();
    logic [MW-1:0] m, exp;
    idle_inputs();
    m = rnd_msg(); m[63:32] = 32'h0000_3008; m[17] = 1'b1;
    msg_in = m; valid_in = 1; flush = 1; exc_valid = 1; exc_code = 5'd9;
    step();
    exp = '0; exp[63:32] = 32'h0000_3008; exp[17] = 1'b1;
    n_tests++;
    if (msg_d !== exp || vld_d !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: msg=%h vld=%b want %h/0", msg_d, vld_d, exp);
    end
  endtask

  task automatic test_stall();
    logic [MW-1:0] m, held;
    idle_inputs();
    m = rnd_msg(); m[3:0] = 4'd5; m[16:12] = 5'd0;
    msg_in = m; valid_in = 1;
    step();
    held = msg_d;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      msg_in = rnd_msg(); valid_in = 1'($urandom);
      step();
    end
    n_tests++;
    if (msg_d !== held || msg_d[3:0] !== 4'd4 || vld_d !== 1'b1 || cnt_d !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_hold: tnew=%0d vld=%b cnt=%0d want 4/1/3", msg_d[3:0], vld_d, cnt_d);
    end
    flush = 1; msg_in = rnd_msg();
    step();
    n_tests++;
    if (msg_d !== held || cnt_d !== 16'd4) begin
      n_fail++;
      $display("FAIL stall_over_flush: cnt=%0d want 4 (held=%b)", cnt_d, msg_d === held);
    end
    flush = 0;
    for (int i = 0; i < 6; i++) step();
    n_tests++;
    if (cnt_c2 !== 2'd3 || cnt_d !== 16'd10) begin
      n_fail++;
      $display("FAIL stall_cnt_sat: cnt2=%0d cnt16=%0d want 3/10", cnt_c2, cnt_d);
    end
  endtask

  task automatic test_req();
    int c0;
    idle_inputs();
    msg_in = rnd_msg(); valid_in = 1;
    step();
    c0 = int'(cnt_d);
    stall = 1; flush = 1; req = 1;
    step();
    n_tests++;
    if (msg_d !== '0 || vld_d !== 1'b0 || int'(cnt_d) !== c0) begin
      n_fail++;
      $display("FAIL req_over_stall: msg=%h vld=%b cnt=%0d want 0/0/%0d", msg_d, vld_d, cnt_d, c0);
    end
    stall = 0; flush = 0; req = 0; msg_in = rnd_msg(); valid_in = 1;
    step();
    req = 1;
    step();
    n_tests++;
    if (msg_d !== '0 || vld_d !== 1'b0) begin
      n_fail++;
      $display("FAIL req_clear: msg=%h vld=%b want 0/0", msg_d, vld_d);
    end
    reset = 0; req = 1; stall = 1;
    step();
    n_tests++;
    if (msg_d !== '0 || vld_d !== 1'b0 || cnt_d !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_over_req: msg=%h vld=%b cnt=%0d want 0/0/0", msg_d, vld_d, cnt_d);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) != 0);
      req       = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      valid_in  = ($urandom_range(0, 3) != 0);
      exc_valid = 1'($urandom);
      exc_code  = 5'($urandom);
      msg_in    = rnd_msg();
      if ($urandom_range(0, 2) == 0) msg_in[16:12] = 5'd0;
      if ($urandom_range(0, 3) == 0) msg_in[3:0] = 4'd0;
      step();
      n_tests++;
      if (msg_d !== e_msg || vld_d !== e_vld || int'(cnt_d) !== e_cnt ||
          msg_nd !== e_nd_msg || int'(cnt_c2) !== e_c2) begin
        n_fail++;
        $display("FAIL random[%0d]: msg=%h vld=%b cnt=%0d nd=%h c2=%0d want %h/%b/%0d/%h/%0d",
                 i, msg_d, vld_d, cnt_d, msg_nd, cnt_c2, e_msg, e_vld, e_cnt, e_nd_msg, e_c2);
      end
    end
  endtask

  initial begin
    e_msg = '0; e_nd_msg = '0; e_vld = 0; e_cnt = 0; e_c2 = 0;
    idle_inputs();
    test_reset();
    test_tnew();
    test_exc();
    test_flush();
    test_stall();
    test_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/msg_pipe_reg.md
Name: msg_pipe_reg

Overview:
- Parametrised pipeline register for the packed per-instruction message bus carried between stages (F/D, D/E, E/M, M/W).
- Adds behaviour a plain field splitter does not have:
  - stall hold and flush-to-bubble with PC/BD preservation;
  - saturating Tnew countdown;
  - first-exception-wins ExcCode injection;
  - a stall-cycle performance counter.
- One instance per stage boundary; downstream stages slice fields from msg_out using the same field map.

Parameters:
- MSG_W, 192, total message width in bits.
- TNEW_LSB, 0, LSB of the Tnew field.
- TNEW_W, 4, Tnew field width.
- EXC_LSB, 12, LSB of the ExcCode field.
- EXC_W, 5, ExcCode field width.
- BD_BIT, 17, bit position of the branch-delay-slot flag.
- PC_LSB, 32, LSB of the 32-bit PC field.
- DEC_TNEW, 1, 1 = decrement Tnew on load; 0 = pass Tnew unchanged.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  stage clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- msg_in  in  MSG_W  message from the upstream stage.
- valid_in  in  1  msg_in holds a real instruction.
- stall  in  1  hold the current contents.
- flush  in  1  load a bubble instead of msg_in.
- req  in  1  exception/interrupt request; clears the stage.
- exc_valid  in  1  upstream stage detected an exception this cycle.
- exc_code  in  EXC_W  code for exc_valid.
- msg_out  out  MSG_W  registered message.
- valid_out  out  1  msg_out is a real instruction.
- stall_cnt  out  CNT_W  cycles spent stalled since reset, saturating.

Behaviour:
- All state updates on the rising clk edge. Latency is 1 cycle; there is no combinational path from inputs to outputs.
- Reset (reset==0 at the edge): msg_out=0, valid_out=0, stall_cnt=0. Reset has priority over every other input.
- Priority per edge: reset > req > stall > flush > load.
- req==1:
  - msg_out=0, valid_out=0.
  - stall and flush are ignored.
  - stall_cnt is not incremented.
- stall==1 (req==0):
  - msg_out and valid_out are held unchanged; Tnew does not decrement.
  - stall_cnt increments by 1 and saturates at 2^CNT_W-1.
  - flush is ignored while stall is asserted; the stage is flushed by the upstream controller instead.
- flush==1 (req==0, stall==0): loads a bubble.
  - msg_out = all zero, except PC field = msg_in[PC_LSB+:32] and BD_BIT = msg_in[BD_BIT], so EPC stays correct for interrupts landing on bubbles.
  - valid_out=0.
- Load (req, stall and flush all 0):
  - msg_out = msg_in, with the field updates below; valid_out = valid_in.
  - Tnew: if DEC_TNEW==1 and the field is nonzero, it is stored minus 1. Tnew==0 stays 0 (saturate, never wraps to 4'hF).
  - ExcCode: if exc_valid==1 and the incoming ExcCode field==0, the stored field = exc_code. If the incoming field is nonzero, it is kept unchanged (earliest exception wins).
  - If valid_in==0, the Tnew and ExcCode updates are suppressed and msg_in is copied verbatim.
- Field-edit rule: all bits outside the Tnew and ExcCode fields pass through bit-exact on load.
- Parameter legality:
  - Field ranges must lie inside MSG_W and must not overlap; BD_BIT must lie outside all other fields.
  - An out-of-range parameter set is a compile-time error (generate-time check).
- stall_cnt counts stall cycles only. It is cleared only by reset.

Test Plan:
- Reset: drive reset=0 for 2 cycles with all inputs toggling -> msg_out=0, valid_out=0, stall_cnt=0. After release with a load of msg_in=192'h...A5, msg_out appears exactly one edge later.
- Tnew countdown: load Tnew=2, then forward msg_out into a second instance -> 1, then 0 at a third instance. Load Tnew=0 -> 0, not F. With DEC_TNEW=0, Tnew=3 -> 3.
- Exception ordering:
  - incoming ExcCode=0, exc_valid=1, exc_code=5'd4 -> stored 4;
  - incoming ExcCode=5'd10, exc_valid=1, exc_code=5'd4 -> stored 10;
  - valid_in=0, exc_valid=1 -> ExcCode unchanged.
- Flush bubble: msg_in with PC=32'h0000_3008, BD=1, other fields random, flush=1 -> msg_out PC=32'h3008, BD=1, all other bits 0, valid_out=0.
- Stall hold and counter: load a message, then assert stall for 3 cycles while msg_in changes -> msg_out unchanged, Tnew not decremented, stall_cnt=3. Assert stall and flush together -> hold, stall_cnt=4. With CNT_W=2, hold stall for 6 cycles -> stall_cnt stays at 3.
- req priority: stall=1, flush=1, req=1 at the same edge -> msg_out=0, valid_out=0, stall_cnt not incremented. req with stall=0 -> same clear. Reset=0 with req=1 -> reset values.
